// File: rtl/ysyx_rou.sv
// ysyx_rou: in-order commit buffer that collects out-of-order completions by tag and retires them in program order.
// Optional YSYX_ROU_BYPASS_EN lets a completion to the head entry retire in the same cycle.
module ysyx_rou #(
  parameter int ROB_SIZE   = 4,
  parameter int REG_ADDR_W = 4,
  parameter int XLEN       = 32,
  parameter int TAG_W      = $clog2(ROB_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  idu_valid,
  input  logic [REG_ADDR_W-1:0] idu_rd,
  output logic                  idu_ready,
  output logic [TAG_W-1:0]      idu_tag,
  input  logic                  exu_valid,
  input  logic [TAG_W-1:0]      exu_tag,
  input  logic [XLEN-1:0]       exu_result,
  input  logic                  exu_mispredict,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  output logic                  bad_speculation,
  output logic                  out_empty
);

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]   valid_q;
  logic [ROB_SIZE-1:0]   done_q;
  logic [ROB_SIZE-1:0]   misp_q;
  logic [REG_ADDR_W-1:0] rd_q   [ROB_SIZE];
  logic [XLEN-1:0]       data_q [ROB_SIZE];
  logic [TAG_W-1:0]      head_q;
  logic [TAG_W-1:0]      tail_q;
  logic [TAG_W:0]        count_q;

  logic            head_ready;
  logic            cpl_hit;
  logic            cpl_fire;
  logic            commit;
  logic            flush;
  logic            disp;
  logic [XLEN-1:0] cm_data;
  logic            cm_misp;

  assign head_ready = valid_q[head_q] & done_q[head_q];
  assign cpl_hit    = exu_valid & valid_q[exu_tag] & ~done_q[exu_tag];

`ifdef YSYX_ROU_BYPASS_EN
  logic bypass_hit;
  // A fresh completion to the head retires straight from the execute bus.
  assign bypass_hit = cpl_hit & (exu_tag == head_q);
  assign commit     = head_ready | bypass_hit;
  assign cm_data    = bypass_hit ? exu_result     : data_q[head_q];
  assign cm_misp    = bypass_hit ? exu_mispredict : misp_q[head_q];
`else
  assign commit     = head_ready;
  assign cm_data    = data_q[head_q];
  assign cm_misp    = misp_q[head_q];
`endif

  assign flush     = commit & cm_misp;
  assign cpl_fire  = cpl_hit & ~flush;
  assign idu_ready = (count_q != CNT_FULL) & ~flush;
  assign disp      = idu_valid & idu_ready;
  assign idu_tag   = tail_q;
  assign out_empty = (count_q == '0);

  assign reg_write_en    = commit & (rd_q[head_q] != '0);
  assign waddr           = commit ? rd_q[head_q] : '0;
  assign wdata           = commit ? cm_data : '0;
  assign bad_speculation = flush;

  // Control state: entry flags and pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      misp_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cpl_fire) begin
        done_q[exu_tag] <= 1'b1;
        misp_q[exu_tag] <= exu_mispredict;
      end
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (commit && head_q == TAG_W'(i)) valid_q[i] <= 1'b0;
        if (disp && tail_q == TAG_W'(i)) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
          misp_q[i]  <= 1'b0;
        end
      end
      if (commit) head_q <= head_q + 1'b1;
      if (disp)   tail_q <= tail_q + 1'b1;
      case ({disp, commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage: only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (disp)     rd_q[tail_q]    <= idu_rd;
    if (cpl_fire) data_q[exu_tag] <= exu_result;
  end

endmodule

// File: tb/tb_ysyx_rou.sv
// Self-checking bench for ysyx_rou: queue-based program-order model plus directed literal scenarios.
module tb_ysyx_rou;
  localparam int ROB_SIZE   = 4;
  localparam int REG_ADDR_W = 4;
  localparam int XLEN       = 32;
  localparam int TAG_W      = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  idu_valid = 1'b0;
  logic [REG_ADDR_W-1:0] idu_rd = '0;
  logic                  idu_ready;
  logic [TAG_W-1:0]      idu_tag;
  logic                  exu_valid = 1'b0;
  logic [TAG_W-1:0]      exu_tag = '0;
  logic [XLEN-1:0]       exu_result = '0;
  logic                  exu_mispredict = 1'b0;
  logic                  reg_write_en;
  logic [REG_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]       wdata;
  logic                  bad_speculation;
  logic                  out_empty;

  always #5 clock = ~clock;

  ysyx_rou #(.ROB_SIZE(ROB_SIZE), .REG_ADDR_W(REG_ADDR_W), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .idu_valid(idu_valid), .idu_rd(idu_rd), .idu_ready(idu_ready), .idu_tag(idu_tag),
    .exu_valid(exu_valid), .exu_tag(exu_tag), .exu_result(exu_result), .exu_mispredict(exu_mispredict),
    .reg_write_en(reg_write_en), .waddr(waddr), .wdata(wdata),
    .bad_speculation(bad_speculation), .out_empty(out_empty)
  );

  typedef struct {
    int          tag;
    int          rd;
    bit          done;
    bit          mis;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          next_tag;
  int          checks = 0;
  int          fails  = 0;
  bit          e_commit, e_bad, e_ready;
  int          e_rd;
  logic [31:0] e_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    e_commit = 0; e_bad = 0; e_rd = 0; e_data = '0;
    if (q.size() > 0) begin
      if (q[0].done) begin
        e_commit = 1; e_rd = q[0].rd; e_data = q[0].data; e_bad = q[0].mis;
      end
`ifdef YSYX_ROU_BYPASS_EN
      else if (exu_valid && int'(exu_tag) == q[0].tag) begin
        e_commit = 1; e_rd = q[0].rd; e_data = exu_result; e_bad = exu_mispredict;
      end
`endif
    end
    e_ready = (q.size() != ROB_SIZE) && !e_bad;
  endtask

  task automatic model_update();
    ent_t e;
    if (e_bad) begin
      q.delete();
      next_tag = 0;
    end else begin
      if (exu_valid) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(exu_tag) && !q[i].done) begin
            q[i].done = 1; q[i].data = exu_result; q[i].mis = exu_mispredict;
          end
        end
      end
      if (e_commit) void'(q.pop_front());
      if (idu_valid && e_ready) begin
        e.tag = next_tag; e.rd = int'(idu_rd); e.done = 0; e.mis = 0; e.data = '0;
        q.push_back(e);
        next_tag = (next_tag + 1) % ROB_SIZE;
      end
    end
  endtask

  // One clock cycle: compare against the model, then advance it at the edge.
  task automatic tick();
    #1;
    model_expect();
    chk("reg_write_en", reg_write_en, e_commit && e_rd != 0);
    chk("waddr", waddr, e_rd);
    chk("wdata", wdata, e_data);
    chk("bad_speculation", bad_speculation, e_bad);
    chk("idu_ready", idu_ready, e_ready);
    chk("idu_tag", idu_tag, next_tag);
    chk("out_empty", out_empty, q.size() == 0);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle();
    idu_valid = 0; idu_rd = '0; exu_valid = 0; exu_tag = '0; exu_result = '0; exu_mispredict = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_empty", out_empty, 1);
    chk("rst_reg_write_en", reg_write_en, 0);
    chk("rst_idu_ready", idu_ready, 1);
    chk("rst_idu_tag", idu_tag, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_bad_speculation", bad_speculation, 0);
    q.delete();
    next_tag = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic disp(input int rd);
    idle(); idu_valid = 1; idu_rd = REG_ADDR_W'(rd); tick();
  endtask

  task automatic cpl(input int tag, input logic [31:0] val, input bit mis);
    idle(); exu_valid = 1; exu_tag = TAG_W'(tag); exu_result = val; exu_mispredict = mis; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();

    // Two dispatches, in-order completions, rd=0 suppresses the write.
    idle(); idu_valid = 1; idu_rd = 4'd5; #1; chk("first_tag", idu_tag, 0); tick();
    disp(0);
    cpl(0, 32'h11, 0);
    idle(); exu_valid = 1; exu_tag = 2'd1; exu_result = 32'h22;
`ifndef YSYX_ROU_BYPASS_EN
    #1; chk("s1_wen", reg_write_en, 1); chk("s1_waddr", waddr, 5); chk("s1_wdata", wdata, 32'h11);
`endif
    tick();
    idle();
`ifndef YSYX_ROU_BYPASS_EN
    #1; chk("s1_rd0_wen", reg_write_en, 0); chk("s1_rd0_wdata", wdata, 32'h22);
`endif
    tick();
    #1; chk("s1_empty", out_empty, 1);

    // Out-of-order completion retires in program order.
    do_reset();
    disp(1); disp(2); disp(3);
    cpl(2, 32'h302, 0); cpl(1, 32'h301, 0);
`ifndef YSYX_ROU_BYPASS_EN
    cpl(0, 32'h300, 0);
    for (int k = 0; k < 3; k++) begin
      idle(); #1;
      chk("s2_wen", reg_write_en, 1);
      chk("s2_waddr", waddr, k + 1);
      chk("s2_wdata", wdata, 32'h300 + k);
      tick();
    end
`else
    cpl(0, 32'h300, 0);
    idle(); tick(); tick();
`endif
    #1; chk("s2_empty", out_empty, 1);

    // Full buffer, slot reuse only after the commit edge, tag wrap.
    do_reset();
    for (int r = 1; r <= 4; r++) disp(r);
    idle(); #1; chk("s3_full_ready", idu_ready, 0);
    cpl(0, 32'hA, 0);
`ifndef YSYX_ROU_BYPASS_EN
    idle(); idu_valid = 1; idu_rd = 4'd9; #1;
    chk("s3_commit_wen", reg_write_en, 1); chk("s3_commit_ready", idu_ready, 0);
    tick();
`endif
    idle(); idu_valid = 1; idu_rd = 4'd9; #1;
    chk("s3_ready_after", idu_ready, 1); chk("s3_wrap_tag", idu_tag, 0);
    tick();
    idle(); #1; chk("s3_not_empty", out_empty, 0);

    // Mispredict flush, then a late completion is ignored.
    do_reset();
    disp(1); disp(2); disp(3);
    cpl(0, 32'h40, 1);
`ifndef YSYX_ROU_BYPASS_EN
    idle(); #1;
    chk("s4_wen", reg_write_en, 1); chk("s4_waddr", waddr, 1);
    chk("s4_wdata", wdata, 32'h40); chk("s4_bad", bad_speculation, 1);
    tick();
`endif
    idle(); exu_valid = 1; exu_tag = 2'd1; exu_result = 32'h55; #1;
    chk("s4_empty", out_empty, 1); chk("s4_tag", idu_tag, 0); chk("s4_bad_off", bad_speculation, 0);
    tick();
    idle(); #1; chk("s4_late_wen", reg_write_en, 0); chk("s4_late_empty", out_empty, 1);
    tick();

    // Duplicate completion to a done tag leaves the stored value alone.
    do_reset();
    disp(7); disp(8);
    cpl(1, 32'h22, 0);
    cpl(1, 32'hFF, 0);
    cpl(0, 32'h11, 0);
`ifndef YSYX_ROU_BYPASS_EN
    idle(); #1; chk("s5_waddr7", waddr, 7); chk("s5_wdata7", wdata, 32'h11); tick();
`endif
    idle(); #1; chk("s5_waddr8", waddr, 8); chk("s5_wdata8", wdata, 32'h22); tick();

    // Asynchronous reset mid-cycle with live entries.
    do_reset();
    disp(1); disp(2); disp(3);
    cpl(0, 32'h5, 0);
    idle(); #3;
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idu_valid      = ($urandom % 10) < 6;
      idu_rd         = REG_ADDR_W'($urandom);
      exu_valid      = ($urandom % 2) == 0;
      exu_tag        = TAG_W'($urandom);
      exu_result     = $urandom;
      exu_mispredict = ($urandom % 16) == 0;
      if (n == 1500) begin
        #3;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
